// File: rtl/mul_seq.sv
// Sequential shift-and-add unsigned multiplier.
// Computes x*y over exactly W clock cycles, presents the low W bits of the
// product on y_bo and flags a nonzero high half on ovf_o. Shares the
// start/ready handshake of the lab's sequential divider.
module mul_seq #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] x_bi,
    input  logic [W-1:0] y_bi,
    input  logic         start_i,
    output logic [W-1:0] y_bo,
    output logic         ovf_o,
    output logic         rdy_o
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t          state;
    state_t          state_n;
    logic [2*W-1:0]  a;
    logic [2*W-1:0]  acc;
    logic [2*W-1:0]  acc_n;
    logic [W-1:0]    b;
    logic [CW-1:0]   cnt;
    logic            last;

    // One conditional accumulate step; 2W bits cannot overflow because the
    // largest possible product is below 2^(2W).
    function automatic logic [2*W-1:0] add_step(input logic [2*W-1:0] acc_v,
                                                input logic [2*W-1:0] a_v,
                                                input logic           en);
        return en ? (acc_v + a_v) : acc_v;
    endfunction

    assign last  = (cnt == CW'(W - 1));
    assign acc_n = add_step(acc, a, b[0]);
    assign rdy_o = (state == IDLE);

    // State register; reset drops any operation in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state: start is only honoured while idle, busy always runs W cycles.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start_i) state_n = BUSY;
            BUSY:    if (last)    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Datapath: load operands on start, iterate while busy, publish on the last step.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a     <= '0;
            b     <= '0;
            acc   <= '0;
            cnt   <= '0;
            y_bo  <= '0;
            ovf_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        a   <= {{W{1'b0}}, x_bi};
                        b   <= y_bi;
                        acc <= '0;
                        cnt <= '0;
                    end
                end
                BUSY: begin
                    acc <= acc_n;
                    a   <= {a[2*W-2:0], 1'b0};
                    b   <= {1'b0, b[W-1:1]};
                    cnt <= cnt + CW'(1);
                    // Result registers hold between completions; only the
                    // final iteration (including its own add) updates them.
                    if (last) begin
                        y_bo  <= acc_n[W-1:0];
                        ovf_o <= |acc_n[2*W-1:W];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq: table-driven products plus hand-written
// multi-cycle sequences, with a scoreboard queue consumed on each rising rdy_o.
`timescale 1ns/1ps
module tb_mul_seq;

    localparam int W = 32;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic [W-1:0] x_bi  = '0;
    logic [W-1:0] y_bi  = '0;
    logic         start_i = 1'b0;
    logic [W-1:0] y_bo;
    logic         ovf_o;
    logic         rdy_o;

    mul_seq #(.W(W)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .x_bi    (x_bi),
        .y_bi    (y_bi),
        .start_i (start_i),
        .y_bo    (y_bo),
        .ovf_o   (ovf_o),
        .rdy_o   (rdy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [W-1:0] y;
        logic         ovf;
    } exp_t;

    typedef struct packed {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] ey;
        logic         eovf;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[6];

    int npass = 0;
    int ntot  = 0;
    int busy_cnt = 0;
    logic rdy_q = 1'b1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    task automatic push_exp(input logic [W-1:0] y, input logic ovf);
        exp_t e;
        e.y   = y;
        e.ovf = ovf;
        sb.push_back(e);
    endtask

    // Wait (on falling edges) until rdy_o reaches lvl, bounded.
    task automatic wait_rdy(input logic lvl);
        int n = 0;
        while (rdy_o !== lvl && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 200) chk("rdy_timeout", 64'(rdy_o), 64'(lvl));
    endtask

    // Monitor: each rising rdy_o is a completion; compare against scoreboard
    // and check that the busy window lasted exactly W cycles.
    always @(negedge clk_i) begin
        exp_t e;
        if (rst_i) begin
            busy_cnt = 0;
            rdy_q    = 1'b1;
        end else begin
            if (!rdy_o) busy_cnt++;
            if (rdy_o && !rdy_q) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 64'(1), 64'(0));
                end else begin
                    e = sb.pop_front();
                    chk("result_y",   64'(y_bo),     64'(e.y));
                    chk("result_ovf", 64'(ovf_o),    64'(e.ovf));
                    chk("busy_len",   64'(busy_cnt), 64'(W));
                end
                busy_cnt = 0;
            end
            rdy_q = rdy_o;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic stable;

        tbl[0] = '{x: 32'h0000_0000, y: 32'hFFFF_FFFF, ey: 32'h0000_0000, eovf: 1'b0};
        tbl[1] = '{x: 32'hDEAD_BEEF, y: 32'h0000_0001, ey: 32'hDEAD_BEEF, eovf: 1'b0};
        tbl[2] = '{x: 32'h0001_0000, y: 32'h0001_0000, ey: 32'h0000_0000, eovf: 1'b1};
        tbl[3] = '{x: 32'hFFFF_FFFF, y: 32'hFFFF_FFFF, ey: 32'h0000_0001, eovf: 1'b1};
        tbl[4] = '{x: 32'h0000_FFFF, y: 32'h0001_0001, ey: 32'hFFFF_FFFF, eovf: 1'b0};
        tbl[5] = '{x: 32'h8000_0000, y: 32'h0000_0002, ey: 32'h0000_0000, eovf: 1'b1};

        // Reset state
        #1;
        chk("reset_rdy", 64'(rdy_o), 64'(1));
        chk("reset_y",   64'(y_bo),  64'(0));
        chk("reset_ovf", 64'(ovf_o), 64'(0));
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;

        // Basic product, start held two cycles (second sample lands in BUSY)
        @(negedge clk_i);
        x_bi = 32'd8; y_bi = 32'd2; start_i = 1'b1;
        push_exp(32'd16, 1'b0);
        @(negedge clk_i);
        @(negedge clk_i);
        start_i = 1'b0;
        wait_rdy(1'b1);
        stable = 1'b1;
        repeat (100) begin
            @(negedge clk_i);
            if (y_bo !== 32'd16 || ovf_o !== 1'b0 || rdy_o !== 1'b1) stable = 1'b0;
        end
        chk("basic_stable", 64'(stable), 64'(1));

        // Table-driven products
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            x_bi = tbl[i].x; y_bi = tbl[i].y; start_i = 1'b1;
            push_exp(tbl[i].ey, tbl[i].eovf);
            @(negedge clk_i);
            start_i = 1'b0;
            x_bi = $urandom; y_bi = $urandom;
            wait_rdy(1'b0);
            wait_rdy(1'b1);
        end

        // Reset mid-operation
        @(negedge clk_i);
        x_bi = 32'd7; y_bi = 32'd9; start_i = 1'b1;
        push_exp(32'd63, 1'b0);
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (9) @(posedge clk_i);
        #2;
        sb.delete();
        rst_i = 1'b1;
        #1;
        chk("midrst_rdy", 64'(rdy_o), 64'(1));
        chk("midrst_y",   64'(y_bo),  64'(0));
        chk("midrst_ovf", 64'(ovf_o), 64'(0));
        @(posedge clk_i);
        #2;
        rst_i = 1'b0;
        @(negedge clk_i);
        x_bi = 32'd3; y_bi = 32'd5; start_i = 1'b1;
        push_exp(32'd15, 1'b0);
        @(negedge clk_i);
        start_i = 1'b0;
        wait_rdy(1'b0);
        wait_rdy(1'b1);

        // Start during BUSY plus operand change
        @(negedge clk_i);
        x_bi = 32'd100; y_bi = 32'd3; start_i = 1'b1;
        push_exp(32'd300, 1'b0);
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (4) @(negedge clk_i);
        x_bi = 32'd1; y_bi = 32'd1; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        wait_rdy(1'b1);

        // Held start: back-to-back operations
        @(negedge clk_i);
        x_bi = 32'd6; y_bi = 32'd7; start_i = 1'b1;
        push_exp(32'd42, 1'b0);
        for (int i = 0; i < 3; i++) begin
            wait_rdy(1'b0);
            wait_rdy(1'b1);
            if (i < 2) begin
                push_exp(32'd42, 1'b0);
                @(negedge clk_i);
                chk("held_rdy_pulse", 64'(rdy_o), 64'(0));
            end else begin
                start_i = 1'b0;
            end
        end

        repeat (5) @(negedge clk_i);
        chk("sb_empty", 64'(sb.size()), 64'(0));

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule

// File: doc/mul_seq.md
# mul_seq

Sequential shift-and-add unsigned multiplier, the companion to the lab's sequential divider. It shares the same start/ready handshake and operand/result port set. It computes x·y over a fixed W cycles, returns the low W bits of the product and flags overflow when the high half is nonzero. Benches use it standalone and as a checker for divider results (q·y + r = x).

## Interface
- W, default 32, operand and result width in bits.

- clk_i  input  1  clock; all state changes on its rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- x_bi  input  W  multiplicand; sampled only on an accepted start.
- y_bi  input  W  multiplier; sampled only on an accepted start.
- start_i  input  1  start request; accepted on a rising edge while idle.
- y_bo  output  W  low W bits of the last completed product.
- ovf_o  output  1  high when the high W bits of the last completed product are nonzero.
- rdy_o  output  1  high while idle and able to accept; low while busy.
- One clock; reset is asynchronous and active-high (clk_i, rst_i).

## Operation
- Two states:
  - IDLE: rdy_o=1.
  - BUSY: rdy_o=0.
- Internal registers:
  - a (2W bits): shifted multiplicand.
  - b (W bits): shifted multiplier.
  - acc (2W bits): accumulator.
  - cnt: ceil(log2 W) bits.
- IDLE with start_i=1 at an edge:
  - a ← zero-extended x_bi; b ← y_bi; acc ← 0; cnt ← 0.
  - rdy_o ← 0; go to BUSY.
- Each BUSY edge:
  - If b[0]=1, acc ← acc + a. The sum is 2W bits and cannot overflow, since the max product is < 2^(2W).
  - a ← a << 1; b ← b >> 1; cnt ← cnt + 1.
- BUSY edge with cnt = W-1 (the W-th iteration):
  - y_bo ← low W bits of the final acc, including this iteration's add.
  - ovf_o ← OR of the high W bits of the final acc.
  - rdy_o ← 1; go to IDLE.
- Fixed latency: no early termination when b reaches 0.
- start_i while BUSY is ignored and does not queue.
- start_i still high in IDLE after completion starts a new operation at that edge. A level-held start therefore chains operations back-to-back.
- y_bo and ovf_o hold their value from one completion until the next completion. They are not cleared on start.
- Operands may change freely after the accepted start edge without affecting the result.

## Timing
- Reset (asynchronous, immediate, including mid-operation):
  - State IDLE; rdy_o=1; y_bo=0; ovf_o=0.
  - a, b, acc, cnt = 0.
  - An aborted operation produces no result.
- Releasing reset puts the block in IDLE. The first start is accepted at the first rising edge where rst_i=0 and start_i=1.
- start accepted at edge k:
  - rdy_o low after edge k.
  - Iterations occur at edges k+1 … k+W.
  - y_bo, ovf_o and rdy_o=1 are all updated together after edge k+W.
  - rdy_o is therefore low for exactly W clock cycles.
- A consumer waits for a rising edge of rdy_o. y_bo and ovf_o are valid from that point and stable until the next completion.
- Back-to-back operation: with start_i held high, the next start is accepted at edge k+W+1, giving a throughput of one result per W+1 cycles.
- Simultaneous reset and start: reset wins.

## Test plan
- **Basic product.** Reset 2 cycles, x_bi=8, y_bi=2, start_i high for 2 cycles (second sample lands in BUSY and is ignored).
  - rdy_o low for exactly 32 cycles.
  - Then y_bo=16, ovf_o=0, rdy_o=1, stable ≥100 cycles.
- **Zeros and identity.**
  - x=0, y=0xFFFFFFFF → y_bo=0, ovf_o=0.
  - x=0xDEADBEEF, y=1 → y_bo=0xDEADBEEF, ovf_o=0.
  - Both complete after 32 busy cycles.
- **Overflow.**
  - x=0x00010000, y=0x00010000 → y_bo=0, ovf_o=1.
  - x=y=0xFFFFFFFF → y_bo=0x00000001, ovf_o=1.
- **Reset mid-operation.** Start x=7, y=9; assert rst_i asynchronously (between edges) at busy cycle 10.
  - rdy_o=1, y_bo=0, ovf_o=0 immediately.
  - A new start with x=3, y=5 yields 15 after 32 cycles.
- **Start during BUSY and operand change.** Start x=100, y=3. At busy cycle 5, pulse start_i and change x_bi=1, y_bi=1.
  - Result is 300, at the original completion time.
- **Held start / back-to-back.** Hold start_i=1 continuously with x=6, y=7.
  - rdy_o high for one cycle every 33 cycles.
  - Each completion gives y_bo=42.
